// File: rtl/mem_dma.sv
// Byte-wide fill/copy bus master for the shared framebuffer memory.
// Copy mode (RD/LAT/WR states, source pointer) is compiled in only when MEM_DMA_COPY_EN is defined.
module mem_dma #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          cmd_start,
    input  logic          cmd_copy,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_val,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_dw,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dr
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_RD   = 3'd2,
        S_LAT  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] dw_q, dw_d;
    logic          we_q, we_d;

`ifdef MEM_DMA_COPY_EN
    logic [AW-1:0] src_q, src_d;
`else
    logic unused_copy_inputs;
    assign unused_copy_inputs = ^{cmd_copy, cmd_src, mem_dr};
`endif

    // dst_q always holds the destination of the byte currently in flight
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        a_d     = a_q;
        dw_d    = dw_q;
        we_d    = we_q;
`ifdef MEM_DMA_COPY_EN
        src_d   = src_q;
`endif
        case (state_q)
            S_IDLE: begin
                we_d = 1'b0;
                if (cmd_start) begin
                    cnt_d = cmd_len;
                    dst_d = cmd_dst;
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end
`ifdef MEM_DMA_COPY_EN
                    else if (cmd_copy) begin
                        src_d   = cmd_src;
                        a_d     = cmd_src;
                        state_d = S_RD;
                    end
`endif
                    else begin
                        a_d     = cmd_dst;
                        dw_d    = cmd_val;
                        we_d    = 1'b1;
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                cnt_d = cnt_q - ONE;
                dst_d = dst_q + ONE;
                if (cnt_q == ONE) begin
                    we_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    a_d = dst_q + ONE;
                end
            end
`ifdef MEM_DMA_COPY_EN
            S_RD: begin
                state_d = S_LAT;
            end
            S_LAT: begin
                // read data for src arrives this cycle; turn the bus around to the write
                dw_d    = mem_dr;
                a_d     = dst_q;
                we_d    = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                we_d  = 1'b0;
                cnt_d = cnt_q - ONE;
                dst_d = dst_q + ONE;
                src_d = src_q + ONE;
                if (cnt_q == ONE) begin
                    state_d = S_DONE;
                end else begin
                    a_d     = src_q + ONE;
                    state_d = S_RD;
                end
            end
`endif
            S_DONE: begin
                we_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                we_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            dw_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            dw_q    <= dw_d;
            we_q    <= we_d;
        end
    end

`ifdef MEM_DMA_COPY_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            src_q <= '0;
        end else begin
            src_q <= src_d;
        end
    end
`endif

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign mem_a  = a_q;
    assign mem_dw = dw_q;
    assign mem_we = we_q;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: directed vector table, randomized commands against a
// byte-level memory model, plus reset-abort and busy-restart sequences.
module tb_mem_dma;
    localparam int AW = 12;
    localparam int DW = 8;
`ifdef MEM_DMA_COPY_EN
    localparam bit COPY_EN = 1'b1;
`else
    localparam bit COPY_EN = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_copy = 1'b0;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [AW-1:0] cmd_len = '0;
    logic [DW-1:0] cmd_val = '0;
    logic          busy, done, mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_dw;
    logic [DW-1:0] mem_dr = '0;

    mem_dma #(.AW(AW), .DW(DW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_start (cmd_start),
        .cmd_copy  (cmd_copy),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .cmd_val   (cmd_val),
        .busy      (busy),
        .done      (done),
        .mem_a     (mem_a),
        .mem_dw    (mem_dw),
        .mem_we    (mem_we),
        .mem_dr    (mem_dr)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] init_val(input logic [11:0] a);
        case (a)
            12'h010: return 8'h11;
            12'h011: return 8'h22;
            12'h012: return 8'h33;
            default: return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5C;
        endcase
    endfunction

    // bus-side memory: synchronous read, data valid the cycle after the address
    logic [7:0] mem [4096];
    bit         wr_flag [4096];
    int         cyc = 0;
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_a]     <= mem_dw;
            wr_flag[mem_a] <= 1'b1;
        end
        mem_dr <= wr_flag[mem_a] ? mem[mem_a] : init_val(mem_a);
    end

    typedef struct {
        int         c;
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t wr_log[$];
    int  done_log[$];
    wr_t exp_wr[$];
    logic [7:0] ref_mem [4096];

    always @(negedge sys_clk) begin
        if (mem_we) wr_log.push_back('{cyc, mem_a, mem_dw});
        if (done) done_log.push_back(cyc);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    // Reference: ascending byte-by-byte transfer; returns the done cycle offset.
    function automatic int model(input bit cp, input logic [11:0] src, input logic [11:0] dst,
                                 input logic [11:0] len, input logic [7:0] val);
        exp_wr.delete();
        for (int k = 0; k < int'(len); k++) begin
            logic [11:0] da;
            logic [11:0] sa;
            logic [7:0]  d;
            da = dst + 12'(k);
            sa = src + 12'(k);
            d  = cp ? ref_mem[sa] : val;
            ref_mem[da] = d;
            exp_wr.push_back('{(cp ? 3*k + 3 : k + 1), da, d});
        end
        return cp ? 3*int'(len) + 1 : int'(len) + 1;
    endfunction

    typedef struct {
        string       nm;
        bit          cp;
        logic [11:0] src;
        logic [11:0] dst;
        logic [11:0] len;
        logic [7:0]  val;
        int          exp_done;
        int          exp_nwr;
        int          restart;
    } vec_t;

    task automatic cmp_writes(input string nm, input int t0);
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            check($sformatf("%s.w%0d.cyc", nm, i), wr_log[i].c - t0, exp_wr[i].c);
            check($sformatf("%s.w%0d.addr", nm, i), wr_log[i].a, exp_wr[i].a);
            check($sformatf("%s.w%0d.data", nm, i), wr_log[i].d, exp_wr[i].d);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int t0;
        int dofs;
        int n;
        bit eff;
        eff  = v.cp && COPY_EN;
        dofs = model(eff, v.src, v.dst, v.len, v.val);
        if (v.exp_done < 0) v.exp_done = dofs;
        if (v.exp_nwr < 0) v.exp_nwr = exp_wr.size();
        @(negedge sys_clk);
        wr_log.delete();
        done_log.delete();
        cmd_copy  = v.cp;
        cmd_src   = v.src;
        cmd_dst   = v.dst;
        cmd_len   = v.len;
        cmd_val   = v.val;
        cmd_start = 1'b1;
        t0 = cyc;
        @(negedge sys_clk);
        cmd_start = 1'b0;
        cmd_copy  = 1'($urandom);
        cmd_src   = 12'($urandom);
        cmd_dst   = 12'($urandom);
        cmd_len   = 12'($urandom);
        cmd_val   = 8'($urandom);
        check({v.nm, ".busy_first"}, busy, 1);
        for (n = 0; n < 20000; n++) begin
            cmd_start = (v.restart > 0) && (cyc - t0 == v.restart);
            if (done) break;
            @(negedge sys_clk);
        end
        check({v.nm, ".done_cycle"}, cyc - t0, v.exp_done);
        @(negedge sys_clk);
        cmd_start = 1'b0;
        check({v.nm, ".busy_after"}, busy, 0);
        check({v.nm, ".done_width"}, done, 0);
        repeat (2) @(negedge sys_clk);
        check({v.nm, ".done_count"}, done_log.size(), 1);
        check({v.nm, ".nwr"}, wr_log.size(), v.exp_nwr);
        cmp_writes(v.nm, t0);
    endtask

    initial begin
        vec_t vecs[9];
        vec_t rv;
        int   t0;
        int   nb;
        int   bad;

        for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(12'(a));

        vecs[0] = '{"fill_basic",    1'b0, 12'h000, 12'h100, 12'd4, 8'hA5, 5, 4, 0};
        vecs[1] = '{"copy_basic",    1'b1, 12'h010, 12'h200, 12'd3, 8'h00, (COPY_EN ? 10 : 4), 3, 0};
        vecs[2] = '{"fill_wrap",     1'b0, 12'h000, 12'hFFE, 12'd4, 8'h3C, 5, 4, 0};
        vecs[3] = '{"zero_len",      1'b0, 12'h000, 12'h700, 12'd0, 8'h99, 1, 0, 1};
        vecs[4] = '{"fill_restart",  1'b0, 12'h000, 12'h300, 12'd6, 8'h42, 7, 6, 2};
        vecs[5] = '{"copy_overlap",  1'b1, 12'h010, 12'h011, 12'd5, 8'h00, (COPY_EN ? 16 : 6), 5, 0};
        vecs[6] = '{"copy_zero",     1'b1, 12'h123, 12'h456, 12'd0, 8'h00, 1, 0, 0};
        vecs[7] = '{"copy_wrap",     1'b1, 12'hFFE, 12'h400, 12'd3, 8'h00, (COPY_EN ? 10 : 4), 3, 4};
        vecs[8] = '{"copy_flag",     1'b1, 12'h100, 12'h600, 12'd2, 8'h5A, (COPY_EN ? 7 : 3), 2, 0};

        // reset values
        #2 sys_rst = 1'b1;
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.mem_a", mem_a, 0);
        check("rst.mem_dw", mem_dw, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("idle.busy", busy, 0);
        check("idle.mem_we", mem_we, 0);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // reset in the middle of a copy (byte 2 latency cycle)
        nb = COPY_EN ? 2 : 7;
        void'(model(COPY_EN, 12'h000, 12'h800, 12'(nb), 8'h77));
        @(negedge sys_clk);
        wr_log.delete();
        done_log.delete();
        cmd_copy = 1'b1; cmd_src = 12'h000; cmd_dst = 12'h800; cmd_len = 12'd8; cmd_val = 8'h77;
        cmd_start = 1'b1;
        t0 = cyc;
        @(negedge sys_clk);
        cmd_start = 1'b0;
        for (int n = 0; n < 20 && (cyc - t0 < 7); n++) @(negedge sys_clk);
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.mem_we", mem_we, 0);
        check("abort.mem_a", mem_a, 0);
        check("abort.mem_dw", mem_dw, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (12) @(negedge sys_clk);
        check("abort.done_count", done_log.size(), 0);
        check("abort.nwr", wr_log.size(), exp_wr.size());
        cmp_writes("abort", t0);
        rv = '{"post_abort_fill", 1'b0, 12'h000, 12'h900, 12'd3, 8'hC3, 4, 3, 0};
        run_cmd(rv);

        // randomized commands
        for (int r = 0; r < 25; r++) begin
            rv.nm       = $sformatf("rnd%0d", r);
            rv.cp       = 1'($urandom_range(0, 1));
            rv.src      = 12'($urandom);
            rv.dst      = 12'($urandom);
            rv.len      = ($urandom_range(0, 6) == 0) ? 12'($urandom_range(20, 40))
                                                      : 12'($urandom_range(0, 9));
            rv.val      = 8'($urandom);
            rv.exp_done = -1;
            rv.exp_nwr  = -1;
            rv.restart  = int'($urandom_range(0, 3));
            run_cmd(rv);
        end

        bad = 0;
        for (int a = 0; a < 4096; a++) begin
            if ((wr_flag[a] ? mem[a] : init_val(12'(a))) !== ref_mem[a]) bad++;
        end
        check("final_memory_mismatches", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
